// File: rtl/mips_defs.sv
// Shared constants and next-PC select encoding for the MIPS pipeline stages.
package mips_defs;

  localparam logic [31:0] NOP_INSTRN = 32'h0000_0000;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_HOLD = 2'd1,
    SEL_BR   = 2'd2,
    SEL_JMP  = 2'd3
  } pc_sel_e;

  // Fetches are word-aligned; low address bits of any target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register with hold and bubble controls; bubble wins over hold.
module if_id_register #(
  parameter int unsigned           DATA_W = 64,
  parameter logic [DATA_W-1:0]     BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (bubble_i) begin
      data_d  = BUBBLE;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: program counter, next-PC selection and the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = mips_defs::RESET_PC,
  parameter int unsigned IMEM_BYTES = 32,
  parameter logic [31:0] NOP_INSTRN = mips_defs::NOP_INSTRN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] instrn_address,
  input  logic [31:0] instrn,
  output logic [31:0] pc,
  output logic [31:0] if_id_instrn,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  if (IMEM_BYTES < 4 || (IMEM_BYTES & (IMEM_BYTES - 1)) != 0) begin : g_bad_imem
    $error("IMEM_BYTES must be a power of two and at least 4");
  end

  mips_defs::pc_sel_e sel;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        squash;

  assign pc_plus4 = pc_q + mips_defs::WORD_BYTES;
  // A redirect comes from an older instruction, so it outranks a stall.
  assign squash   = branch_taken | jump | flush;

  always_comb begin
    sel = mips_defs::SEL_SEQ;
    if (branch_taken)  sel = mips_defs::SEL_BR;
    else if (jump)     sel = mips_defs::SEL_JMP;
    else if (stall)    sel = mips_defs::SEL_HOLD;
  end

  always_comb begin
    pc_d = pc_plus4;
    case (sel)
      mips_defs::SEL_BR:   pc_d = mips_defs::word_align(branch_target);
      mips_defs::SEL_JMP:  pc_d = mips_defs::word_align(jump_target);
      mips_defs::SEL_HOLD: pc_d = pc_q;
      default:             pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc             = pc_q;
  assign instrn_address = pc_q;

  logic [63:0] if_id_data;

  if_id_register #(
    .DATA_W (64),
    .BUBBLE ({NOP_INSTRN, 32'h0000_0000})
  ) u_if_id (
    .clk      (clk),
    .rst      (reset),
    .hold_i   (stall),
    .bubble_i (squash),
    .data_i   ({instrn, pc_plus4}),
    .data_o   (if_id_data),
    .valid_o  (if_id_valid)
  );

  assign if_id_instrn   = if_id_data[63:32];
  assign if_id_pc_plus4 = if_id_data[31:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural memory and a scoreboard queue.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] instrn_address, instrn, pc;
  logic [31:0] if_id_instrn, if_id_pc_plus4;
  logic        if_id_valid;

  logic [31:0] mem [8];

  always #5 clk = ~clk;

  assign instrn = mem[instrn_address[4:2]];

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (32),
    .NOP_INSTRN (NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .instrn_address (instrn_address),
    .instrn         (instrn),
    .pc             (pc),
    .if_id_instrn   (if_id_instrn),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instrn;
    logic [31:0] pp4;
    logic        valid;
  } exp_t;

  exp_t sb [$];

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [31:0] m_pc, m_ii, m_pp4;
  logic        m_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic rs, input logic st, input logic fl,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    exp_t e, got_e;
    @(negedge clk);
    reset = rs; stall = st; flush = fl;
    branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt;
    if (rs) begin
      e.pc = 32'h0; e.instrn = NOP; e.pp4 = 32'h0; e.valid = 1'b0;
    end else begin
      if (br)      e.pc = {bt[31:2], 2'b00};
      else if (jp) e.pc = {jt[31:2], 2'b00};
      else if (st) e.pc = m_pc;
      else         e.pc = m_pc + 32'd4;
      if (br || jp || fl) begin
        e.instrn = NOP; e.pp4 = 32'h0; e.valid = 1'b0;
      end else if (st) begin
        e.instrn = m_ii; e.pp4 = m_pp4; e.valid = m_v;
      end else begin
        e.instrn = mem[m_pc[4:2]]; e.pp4 = m_pc + 32'd4; e.valid = 1'b1;
      end
    end
    sb.push_back(e);
    m_pc = e.pc; m_ii = e.instrn; m_pp4 = e.pp4; m_v = e.valid;
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    chk("pc", pc, got_e.pc);
    chk("instrn_address", instrn_address, got_e.pc);
    chk("if_id_instrn", if_id_instrn, got_e.instrn);
    chk("if_id_pc_plus4", if_id_pc_plus4, got_e.pp4);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, got_e.valid});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    mem[0] = 32'h2008_0005; mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020; mem[3] = 32'hAC0A_0000;
    mem[4] = 32'h8C0B_0000; mem[5] = 32'h116A_0002;
    mem[6] = 32'h0800_0003; mem[7] = 32'h3C0C_1234;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;

    // Reset held for two cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset_pc", pc, 32'h0);

    // First free-running edge
    run(1);
    chk("first_pc", pc, 32'd4);
    chk("first_instrn", if_id_instrn, 32'h2008_0005);
    chk("first_pp4", if_id_pc_plus4, 32'd4);

    // Sequential fetch across the memory wrap
    run(8);
    chk("wrap_pc", pc, 32'd36);
    chk("wrap_instrn", if_id_instrn, 32'h2008_0005);
    chk("wrap_pp4", if_id_pc_plus4, 32'd36);

    // Stall three cycles at pc=8
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    run(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_pc", pc, 32'd8);
    chk("stall_instrn", if_id_instrn, 32'h2009_0003);
    run(1);
    chk("unstall_pc", pc, 32'd12);
    chk("unstall_instrn", if_id_instrn, 32'h0109_5020);

    // Branch under stall with unaligned target
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0006, 1'b0, 32'h0);
    chk("br_stall_pc", pc, 32'd4);
    chk("br_stall_valid", {31'd0, if_id_valid}, 32'd0);

    // Branch and jump together
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd16, 1'b1, 32'd24);
    chk("br_jmp_pc", pc, 32'd16);

    // Flush alone at pc=20
    run(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("flush_pc", pc, 32'd24);

    // Flush with stall keeps pc, bubbles IF/ID
    run(1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("flush_stall_pc", pc, 32'd28);

    // Jump to top of address space, then wrap to zero
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    chk("jmp_top_pc", pc, 32'hFFFF_FFFC);
    run(1);
    chk("pc_wrap0", pc, 32'h0);
    chk("pc_wrap_instrn", if_id_instrn, 32'h3C0C_1234);

    // Reset together with a branch
    run(2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd20, 1'b0, 32'h0);
    chk("rst_br_pc", pc, 32'h0);
    run(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
